// File: rtl/reg_read_stage_pkg.sv
// Shared constants for the register-read pipeline stage: datapath width,
// register count, register-address width, operand field positions and the zero register.
package reg_read_stage_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam int RS1_HI = 25;
    localparam int RS1_LO = 21;
    localparam int RS2_HI = 20;
    localparam int RS2_LO = 16;

    localparam logic [AW-1:0] ZERO_REG = '0;

    function automatic logic [AW-1:0] get_rs1(input logic [31:0] instr);
        return instr[RS1_HI:RS1_LO];
    endfunction

    function automatic logic [AW-1:0] get_rs2(input logic [31:0] instr);
        return instr[RS2_HI:RS2_LO];
    endfunction

endpackage

// File: rtl/reg_read_stage_regfile_2r1w.sv
// Architectural register file: two combinational read ports and one clocked write port.
// r0 is hardwired to zero, and every register is cleared by the asynchronous reset.
module regfile_2r1w #(
    parameter int XLEN = reg_read_stage_pkg::XLEN,
    parameter int NREG = reg_read_stage_pkg::NREG
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [reg_read_stage_pkg::AW-1:0] ra1_i,
    input  logic [reg_read_stage_pkg::AW-1:0] ra2_i,
    output logic [XLEN-1:0]                   rd1_o,
    output logic [XLEN-1:0]                   rd2_o,
    input  logic                              we_i,
    input  logic [reg_read_stage_pkg::AW-1:0] wa_i,
    input  logic [XLEN-1:0]                   wd_i
);
    import reg_read_stage_pkg::*;

    logic [XLEN-1:0] mem_q [NREG];
    logic            wr_en;

    assign wr_en = we_i && (wa_i != ZERO_REG) && (int'(wa_i) < NREG);

    // Entry 0 is cleared by reset and never written, so it only ever holds zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = ((ra1_i == ZERO_REG) || (int'(ra1_i) >= NREG)) ? '0 : mem_q[ra1_i];
    assign rd2_o = ((ra2_i == ZERO_REG) || (int'(ra2_i) >= NREG)) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: reads rs1/rs2 and latches the operands with the instruction.
// Define REG_READ_STAGE_BYPASS_EN to forward same-edge writebacks into the latched operands.
module reg_read_stage #(
    parameter int XLEN = reg_read_stage_pkg::XLEN,
    parameter int NREG = reg_read_stage_pkg::NREG
) (
    input  logic                              CLOCK,
    input  logic                              RESET,
    input  logic [XLEN-1:0]                   instruction,
    input  logic                              id_valid,
    input  logic                              stall,
    input  logic                              wb_en,
    input  logic [reg_read_stage_pkg::AW-1:0] wb_addr,
    input  logic [XLEN-1:0]                   wb_data,
    output logic [XLEN-1:0]                   RD1,
    output logic [XLEN-1:0]                   RD2,
    output logic [XLEN-1:0]                   instructionR,
    output logic                              rd_valid
);
    import reg_read_stage_pkg::*;

    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [AW-1:0]   held_rs1, held_rs2;
    logic [XLEN-1:0] rf_rd1, rf_rd2;
    logic [XLEN-1:0] rd1_q, rd1_d;
    logic [XLEN-1:0] rd2_q, rd2_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            wb_live;

    assign rs1_addr = instruction[RS1_HI:RS1_LO];
    assign rs2_addr = instruction[RS2_HI:RS2_LO];
    assign held_rs1 = instr_q[RS1_HI:RS1_LO];
    assign held_rs2 = instr_q[RS2_HI:RS2_LO];
    assign wb_live  = wb_en && (wb_addr != ZERO_REG);

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk   (CLOCK),
        .rst   (RESET),
        .ra1_i (rs1_addr),
        .ra2_i (rs2_addr),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (wb_en),
        .wa_i  (wb_addr),
        .wd_i  (wb_data)
    );

    always_comb begin
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (!stall) begin
            rd1_d   = rf_rd1;
            rd2_d   = rf_rd2;
            instr_d = instruction;
            valid_d = id_valid;
`ifdef REG_READ_STAGE_BYPASS_EN
            if (wb_live && (wb_addr == rs1_addr)) rd1_d = wb_data;
            if (wb_live && (wb_addr == rs2_addr)) rd2_d = wb_data;
`endif
        end else begin
`ifdef REG_READ_STAGE_BYPASS_EN
            // Keep held operands coherent with writebacks that land during the stall.
            if (wb_live && (wb_addr == held_rs1)) rd1_d = wb_data;
            if (wb_live && (wb_addr == held_rs2)) rd2_d = wb_data;
`endif
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rd1_q   <= '0;
            rd2_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign RD1          = rd1_q;
    assign RD2          = rd2_q;
    assign instructionR = instr_q;
    assign rd_valid     = valid_q;

`ifndef REG_READ_STAGE_BYPASS_EN
    // Held source fields only matter when forwarding is compiled in.
    logic unused_held;
    assign unused_held = ^{held_rs1, held_rs2, wb_live};
`endif

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed self-checking bench for reg_read_stage; expectations follow REG_READ_STAGE_BYPASS_EN.
module tb_reg_read_stage;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [31:0] instruction;
    logic        id_valid;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] RD1, RD2, instructionR;
    logic        rd_valid;

    int checks = 0;
    int errors = 0;

`ifdef REG_READ_STAGE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 CLOCK = ~CLOCK;

    reg_read_stage dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .instruction  (instruction),
        .id_valid     (id_valid),
        .stall        (stall),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .RD1          (RD1),
        .RD2          (RD2),
        .instructionR (instructionR),
        .rd_valid     (rd_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [15:0] tag);
        return {6'h3F, rs1, rs2, tag};
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        id_valid = 1'b0; stall = 1'b0;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [15:0] tag,
                         input logic valid);
        instruction = mk_instr(rs1, rs2, tag);
        id_valid = valid; stall = 1'b0;
        tick();
    endtask

    logic [31:0] held_instr;
    logic [3:0]  vpat;

    initial begin
        RESET = 1'b1; instruction = '0; id_valid = 1'b0; stall = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #2;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);
        check("reset_instr", instructionR, 32'h0);
        check("reset_valid", {31'b0, rd_valid}, 32'h0);
        #10 RESET = 1'b0;

        // basic write then read, one-cycle latency
        write_reg(5'd5, 32'hDEADBEEF);
        issue(5'd5, 5'd0, 16'h0001, 1'b1);
        check("wr_rd1", RD1, 32'hDEADBEEF);
        check("wr_rd2_r0", RD2, 32'h0);
        check("wr_valid", {31'b0, rd_valid}, 32'h1);
        check("wr_instr", instructionR, mk_instr(5'd5, 5'd0, 16'h0001));

        // writes to r0 are discarded
        write_reg(5'd0, 32'h12345678);
        issue(5'd0, 5'd0, 16'h0002, 1'b1);
        check("r0_rd1", RD1, 32'h0);
        check("r0_rd2", RD2, 32'h0);

        // rs1 == rs2
        write_reg(5'd3, 32'hCAFE0003);
        issue(5'd3, 5'd3, 16'h0003, 1'b1);
        check("same_rd1", RD1, 32'hCAFE0003);
        check("same_rd2", RD2, 32'hCAFE0003);

        // same-edge write/read collision
        write_reg(5'd7, 32'h1);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2;
        issue(5'd7, 5'd5, 16'h0004, 1'b1);
        wb_en = 1'b0;
        check("coll_rd1", RD1, BYPASS ? 32'h2 : 32'h1);
        check("coll_rd2", RD2, 32'hDEADBEEF);
        issue(5'd7, 5'd0, 16'h0005, 1'b1);
        check("coll_after", RD1, 32'h2);

        // wb_en=0 writes nothing
        wb_en = 1'b0; wb_addr = 5'd7; wb_data = 32'hFFFF0000;
        issue(5'd0, 5'd0, 16'h0006, 1'b0);
        issue(5'd7, 5'd0, 16'h0007, 1'b1);
        check("noen_rd1", RD1, 32'h2);

        // stall with writeback to the held rs2
        write_reg(5'd9, 32'h55);
        issue(5'd5, 5'd9, 16'h0008, 1'b1);
        held_instr = mk_instr(5'd5, 5'd9, 16'h0008);
        check("pre_stall_rd2", RD2, 32'h55);
        instruction = mk_instr(5'd1, 5'd2, 16'h0BAD);
        id_valid = 1'b0; stall = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hAA;
        tick();
        wb_en = 1'b0;
        tick();
        tick();
        check("stall_instr", instructionR, held_instr);
        check("stall_rd1", RD1, 32'hDEADBEEF);
        check("stall_rd2", RD2, BYPASS ? 32'hAA : 32'h55);
        check("stall_valid", {31'b0, rd_valid}, 32'h1);
        issue(5'd0, 5'd9, 16'h0009, 1'b1);
        check("stall_wrote", RD2, 32'hAA);

        // back-to-back valid pattern 1,0,1,1
        vpat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            issue(5'd3, 5'd9, 16'h0010 + 16'(i), vpat[i]);
            check($sformatf("flow_valid%0d", i), {31'b0, rd_valid}, {31'b0, vpat[i]});
            check($sformatf("flow_instr%0d", i), instructionR, mk_instr(5'd3, 5'd9, 16'h0010 + 16'(i)));
        end

        // reset mid-run with loaded registers and a pending write
        issue(5'd5, 5'd3, 16'h0020, 1'b1);
        check("pre_rst_rd1", RD1, 32'hDEADBEEF);
        #2 RESET = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44444444;
        #1;
        check("rst_rd1", RD1, 32'h0);
        check("rst_rd2", RD2, 32'h0);
        check("rst_valid", {31'b0, rd_valid}, 32'h0);
        tick();
        check("rst_hold_valid", {31'b0, rd_valid}, 32'h0);
        #2 RESET = 1'b0;
        wb_en = 1'b0;
        for (int r = 1; r < 32; r++) begin
            issue(5'(r), 5'(r), 16'h0100, 1'b1);
            check($sformatf("post_rst_r%0d", r), RD1 | RD2, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_read_stage.md
REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: data and instruction width.
REQ-002 The block SHALL have parameter NREG, default 32: number of architectural registers, so register addresses are 5 bits.
REQ-003 The block SHALL have port CLOCK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port instruction, input, XLEN bits: decoded-stage instruction; rs1 = [25:21], rs2 = [20:16].
REQ-006 The block SHALL have port id_valid, input, 1 bit: instruction carries a real operation.
REQ-007 The block SHALL have port stall, input, 1 bit: downstream hold request.
REQ-008 The block SHALL have port wb_en, input, 1 bit: writeback write request.
REQ-009 The block SHALL have port wb_addr, input, 5 bits: writeback destination register.
REQ-010 The block SHALL have port wb_data, input, XLEN bits: writeback value.
REQ-011 The block SHALL have port RD1, output, XLEN bits: registered rs1 operand.
REQ-012 The block SHALL have port RD2, output, XLEN bits: registered rs2 operand.
REQ-013 The block SHALL have port instructionR, output, XLEN bits: instruction registered alongside RD1/RD2.
REQ-014 The block SHALL have port rd_valid, output, 1 bit: RD1/RD2/instructionR hold a valid operation.

Function
REQ-015 On a rising edge with stall=0, the block SHALL load RD1 <= reg[rs1], RD2 <= reg[rs2], instructionR <= instruction and rd_valid <= id_valid. Read latency is 1 cycle.
REQ-016 On a rising edge with stall=1, the block SHALL hold RD1, RD2, instructionR and rd_valid, except as stated in REQ-021.
REQ-017 On a rising edge with wb_en=1 and wb_addr!=0, the block SHALL write reg[wb_addr] <= wb_data, regardless of stall.
REQ-018 Register 0 SHALL always read as 0, and any write to it SHALL be discarded.
REQ-019 A write with wb_en=0 SHALL change no register.
REQ-020 When a write and a read of the same nonzero address occur on the same edge, the operand value SHALL follow the Configuration section.
REQ-021 With bypass enabled, while stall=1, a write whose wb_addr equals the held instructionR rs1 or rs2 field (nonzero) SHALL also update the matching RD1 and/or RD2. Without bypass, RD1 and RD2 SHALL stay unchanged.
REQ-022 rs1 = rs2 SHALL yield identical RD1 and RD2 values.

Reset
REQ-023 While RESET=1, the block SHALL asynchronously clear all registers, RD1, RD2 and instructionR to 0, and clear rd_valid to 0.
REQ-024 A reset asserted mid-operation SHALL drop any held or in-flight operation; no write SHALL complete on the edge coincident with RESET=1.
REQ-025 The first edge after RESET deasserts SHALL behave per REQ-015 and REQ-017.

Configuration
REQ-026 The macro REG_READ_STAGE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-027 With REG_READ_STAGE_BYPASS_EN defined, on a same-edge write and read of an equal nonzero address, the block SHALL capture wb_data into RD1/RD2, and REQ-021 forwarding SHALL be active.
REQ-028 With REG_READ_STAGE_BYPASS_EN undefined, on a same-edge write and read of an equal nonzero address, the block SHALL capture the pre-write value, and software SHALL insert one bubble.

Structure
REQ-029 A shared package SHALL hold XLEN, NREG, the register-address width, the RS1/RS2 field bit positions, and the zero-register constant.
REQ-030 The block SHALL instantiate one sub-module, regfile_2r1w: 2 asynchronous read ports, 1 synchronous write port, r0 hardwired to zero, and async reset clear. Pipeline latching and bypass logic SHALL remain in reg_read_stage.

Verification
REQ-031 Reset: assert RESET mid-run with registers loaded -> RD1=RD2=0, rd_valid=0 immediately, and all registers read 0 afterwards.
REQ-032 Write/read: write r5=0xDEADBEEF; next cycle issue an instruction with rs1=5, rs2=0 -> one edge later RD1=0xDEADBEEF, RD2=0, rd_valid=1.
REQ-033 r0 write: wb_en=1, wb_addr=0, wb_data=0x12345678 -> a subsequent read of r0 gives 0.
REQ-034 Same-edge collision: r7=0x1, then write r7=0x2 on the same edge as reading rs1=7 -> RD1=0x2 with bypass defined, RD1=0x1 without it.
REQ-035 Stall: hold stall=1 for 3 cycles with instructionR rs2=9 and write r9=0xAA -> instructionR unchanged; RD2=0xAA with bypass, old value without it; rd_valid unchanged.
REQ-036 Back-to-back flow: 4 consecutive instructions with id_valid=1,0,1,1 and stall=0 -> rd_valid sequence 1,0,1,1, one cycle delayed.
